multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_inst_classifier.sv | 84 ++++++++
 rtl/multicycle_controller.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multi-cycle control FSM
// Purpose: state and instruction-class enums, pc_src/wb_sel encodings and
//          opcode field values used by the classifier and the controller.
// Ports:   none (package).
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_IOWAIT = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_LD   = 4'd1,
        C_ST   = 4'd2,
        C_LI   = 4'd3,
        C_B    = 4'd4,
        C_BCC  = 4'd5,
        C_CALC = 4'd6,
        C_IN   = 4'd7,
        C_OUT  = 4'd8,
        C_HLT  = 4'd9
    } cls_t;

    // PC source select
    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;

    // Register file write-back source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_IN  = 2'b11;

    // op1 major opcode groups
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 sub-opcodes inside the OP1_IMM group
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    // op3 function codes inside the OP1_ALU group
    localparam logic [3:0] OP3_CALC_MAX = 4'b1011;
    localparam logic [3:0] OP3_IN       = 4'b1100;
    localparam logic [3:0] OP3_OUT      = 4'b1101;
    localparam logic [3:0] OP3_NOP      = 4'b1110;
    localparam logic [3:0] OP3_HLT      = 4'b1111;

    // States in which the watchdog counts consecutive non-ready cycles
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM) || (s == S_IOWAIT);
    endfunction

endpackage

// File: rtl/multicycle_controller_inst_classifier.sv
// rtl/multicycle_controller_inst_classifier.sv - combinational instruction decode
// Purpose: maps the IR word to an instruction class plus the static datapath
//          controls that depend only on the instruction.
// Ports:   inst    - IR contents
//          cls     - instruction class (cls_t encoding)
//          wb_sel  - write-back source for the class
//          reg_dst - 1: destination in inst[10:8], 0: inst[13:11]
//          alu_src - 1: ALU second operand is the immediate offset (LD/ST)
//          calc    - ALU-register operation (CALC class)
//          alu_op  - op1 field
module multicycle_controller_inst_classifier
    import multicycle_controller_pkg::*;
#(
    parameter int INST_W = 16
) (
    input  logic [INST_W-1:0] inst,
    output logic [3:0]        cls,
    output logic [1:0]        wb_sel,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              calc,
    output logic [1:0]        alu_op
);

    logic [1:0] op1;
    logic [2:0] op2;
    logic [3:0] op3;
    cls_t       cls_d;

    assign op1 = inst[INST_W-1 -: 2];
    assign op2 = inst[INST_W-3 -: 3];
    assign op3 = inst[7:4];

    always_comb begin
        cls_d = C_NOP;
        case (op1)
            OP1_LD: cls_d = C_LD;
            OP1_ST: cls_d = C_ST;
            OP1_IMM: begin
                case (op2)
                    OP2_LI:  cls_d = C_LI;
                    OP2_B:   cls_d = C_B;
                    OP2_BCC: cls_d = C_BCC;
                    default: cls_d = C_NOP;
                endcase
            end
            default: begin
                // OP1_ALU: low function codes are ALU ops, the top four are special
                if (op3 <= OP3_CALC_MAX) begin
                    cls_d = C_CALC;
                end else begin
                    case (op3)
                        OP3_IN:  cls_d = C_IN;
                        OP3_OUT: cls_d = C_OUT;
                        OP3_HLT: cls_d = C_HLT;
                        default: cls_d = C_NOP;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        wb_sel = WB_ALU;
        case (cls_d)
            C_LD:    wb_sel = WB_MEM;
            C_LI:    wb_sel = WB_IMM;
            C_IN:    wb_sel = WB_IN;
            default: wb_sel = WB_ALU;
        endcase
    end

    assign cls     = cls_d;
    // Formats with op1[1]=1 keep op2 in [13:11], so their register field moves down
    assign reg_dst = op1[1];
    assign alu_src = ~op1[1];
    assign calc    = (cls_d == C_CALC);
    assign alu_op  = op1;

    // Register-number and immediate bits are consumed by the datapath, not here
    logic unused_inst;
    assign unused_inst = ^inst;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle control FSM with stall watchdog
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
//          handles memory wait-states, IN/OUT handshakes, HLT/restart and a
//          watchdog that halts with fault on a stuck wait state.
// Ports:   clk, rst_n (async, active-low)
//          inst, imem_ready, dmem_ready, branch_taken, in_valid, out_ready, restart
//          imem_req, ir_write, pc_write, pc_src       - fetch / PC control
//          dmem_req, dmem_we                          - data memory access
//          reg_write, reg_dst, wb_sel                 - register write-back
//          alu_src, calc, alu_op                      - static ALU controls
//          in_ready, out_valid                        - IO handshake
//          halted, fault, state                       - debug / status
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int INST_W      = 16,
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              branch_taken,
    input  logic              in_valid,
    input  logic              out_ready,
    input  logic              restart,
    output logic              imem_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              reg_write,
    output logic              reg_dst,
    output logic [1:0]        wb_sel,
    output logic              alu_src,
    output logic              calc,
    output logic [1:0]        alu_op,
    output logic              in_ready,
    output logic              out_valid,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(STALL_LIMIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wdog_q;
    logic             fault_q;
    logic             waiting;
    logic             expire;

    logic [3:0]       cls_raw;
    cls_t             cls;
    logic [1:0]       cls_wb_sel;
    logic             c_reg_dst, c_alu_src, c_calc;
    logic [1:0]       c_alu_op;
    logic             ctrl_valid;

    multicycle_controller_inst_classifier #(
        .INST_W (INST_W)
    ) u_classifier (
        .inst    (inst),
        .cls     (cls_raw),
        .wb_sel  (cls_wb_sel),
        .reg_dst (c_reg_dst),
        .alu_src (c_alu_src),
        .calc    (c_calc),
        .alu_op  (c_alu_op)
    );

    assign cls = cls_t'(cls_raw);

    // IR is only meaningful after the fetch completes; keep static controls
    // quiet before that so nothing toggles during reset or fetch.
    assign ctrl_valid = (state_q != S_IDLE) && (state_q != S_FETCH);
    assign reg_dst    = ctrl_valid & c_reg_dst;
    assign alu_src    = ctrl_valid & c_alu_src;
    assign calc       = ctrl_valid & c_calc;
    assign alu_op     = ctrl_valid ? c_alu_op : 2'b00;

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_INC;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        waiting   = is_wait_state(state_q);
        expire    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                case (cls)
                    C_CALC, C_LD, C_ST, C_LI, C_B, C_BCC: state_d = S_EXEC;
                    C_IN, C_OUT:                          state_d = S_IOWAIT;
                    C_HLT:                                state_d = S_HALT;
                    default:                              state_d = S_FETCH;
                endcase
            end

            S_EXEC: begin
                case (cls)
                    C_LD, C_ST:   state_d = S_MEM;
                    C_CALC, C_LI: state_d = S_WB;
                    C_B: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        state_d  = S_FETCH;
                    end
                    C_BCC: begin
                        pc_write = branch_taken;
                        pc_src   = branch_taken ? PC_BR : PC_INC;
                        state_d  = S_FETCH;
                    end
                    default:      state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_ST);
                if (dmem_ready) begin
                    state_d = (cls == C_ST) ? S_FETCH : S_WB;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = cls_wb_sel;
                state_d   = S_FETCH;
            end

            S_IOWAIT: begin
                if (cls == C_IN) begin
                    in_ready = 1'b1;
                    // The accepting cycle doubles as the write-back cycle
                    if (in_valid) begin
                        reg_write = 1'b1;
                        wb_sel    = WB_IN;
                        state_d   = S_FETCH;
                    end
                end else if (cls == C_OUT) begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                if (restart) begin
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Watchdog only fires when the wait state would otherwise hold; a
        // ready on the final allowed cycle has already moved state_d away.
        // Requests stay asserted that cycle, but no enable can fire without ready.
        if (waiting && (state_d == state_q) && (wdog_q == WDOG_LAST)) begin
            expire  = 1'b1;
            state_d = S_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_d != state_q) || !waiting) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + CNT_W'(1);
            end

            if (expire) begin
                fault_q <= 1'b1;
            end else if ((state_q == S_HALT) && restart) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int INST_W      = 16;
    localparam int STALL_LIMIT = 6;
    localparam int CNT_W       = 3;

    // Control vector bit positions:
    // [13]imem_req [12]ir_write [11]pc_write [10:9]pc_src [8]dmem_req [7]dmem_we
    // [6]reg_write [5:4]wb_sel [3]in_ready [2]out_valid [1]halted [0]fault
    localparam logic [13:0] B_IREQ = 14'h2000;
    localparam logic [13:0] B_IRW  = 14'h1000;
    localparam logic [13:0] B_PCW  = 14'h0800;
    localparam logic [13:0] PC_J   = 14'h0200;
    localparam logic [13:0] PC_B   = 14'h0400;
    localparam logic [13:0] B_DREQ = 14'h0100;
    localparam logic [13:0] B_DWE  = 14'h0080;
    localparam logic [13:0] B_RW   = 14'h0040;
    localparam logic [13:0] W_MEM  = 14'h0010;
    localparam logic [13:0] W_IMM  = 14'h0020;
    localparam logic [13:0] W_IN   = 14'h0030;
    localparam logic [13:0] B_INR  = 14'h0008;
    localparam logic [13:0] B_OV   = 14'h0004;
    localparam logic [13:0] B_HLT  = 14'h0002;
    localparam logic [13:0] B_FLT  = 14'h0001;
    localparam logic [13:0] P_FGO  = B_IREQ | B_IRW | B_PCW;

    // Static controls {reg_dst, alu_src, calc, alu_op}
    localparam logic [4:0] ST_CALC = 5'b10111;
    localparam logic [4:0] ST_LD   = 5'b01000;
    localparam logic [4:0] ST_ST   = 5'b01001;
    localparam logic [4:0] ST_IMM  = 5'b10010;
    localparam logic [4:0] ST_IO   = 5'b10011;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [INST_W-1:0] inst;
    logic              imem_ready, dmem_ready, branch_taken, in_valid, out_ready, restart;
    logic              imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write;
    logic              reg_dst, alu_src, calc, in_ready, out_valid, halted, fault;
    logic [1:0]        pc_src, wb_sel, alu_op;
    logic [2:0]        state_o;

    always #5 clk = ~clk;

    multicycle_controller #(
        .INST_W      (INST_W),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .restart      (restart),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .wb_sel       (wb_sel),
        .alu_src      (alu_src),
        .calc         (calc),
        .alu_op       (alu_op),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .halted       (halted),
        .fault        (fault),
        .state        (state_o)
    );

    typedef struct packed {
        logic [63:0] tag;
        logic [2:0]  st;
        logic [13:0] fl;
        logic [4:0]  s;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [13:0] obs_fl;
    logic [4:0]  obs_s;
    logic [4:0]  cur_s;
    int          total = 0;
    int          bad   = 0;

    // Push the expected response for the current cycle, then advance one clock
    task automatic cyc(input state_t st, input logic [13:0] fl, input logic [63:0] tag);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.fl  = fl;
        e.s   = ((st == S_IDLE) || (st == S_FETCH)) ? 5'b0 : cur_s;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input logic [63:0] tag);
        imem_ready = 1'b1;
        cyc(S_FETCH, P_FGO, tag);
        imem_ready = 1'b0;
    endtask

    task automatic decode(input logic [15:0] word, input logic [4:0] s, input logic [63:0] tag);
        inst  = word;
        cur_s = s;
        cyc(S_DECODE, 14'h0, tag);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e  = sb.pop_front();
            obs_fl = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write,
                      wb_sel, in_ready, out_valid, halted, fault};
            obs_s  = {reg_dst, alu_src, calc, alu_op};
            total  = total + 1;
            if ((state_o !== mon_e.st) || (obs_fl !== mon_e.fl) || (obs_s !== mon_e.s)) begin
                bad = bad + 1;
                $display("FAIL %0s: got state=%0d ctl=%h stat=%b, want state=%0d ctl=%h stat=%b",
                         mon_e.tag, state_o, obs_fl, obs_s, mon_e.st, mon_e.fl, mon_e.s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; inst = '0; cur_s = '0;
        imem_ready = 0; dmem_ready = 0; branch_taken = 0;
        in_valid = 0; out_ready = 0; restart = 0;
        @(posedge clk); #1;
        cyc(S_IDLE, 14'h0, "rst");
        rst_n = 1'b1;
        cyc(S_IDLE, 14'h0, "idle");

        // CALC: FETCH, DECODE, EXEC, WB (4 cycles)
        fetch_ok("calc_f");
        decode(16'hC030, ST_CALC, "calc_d");
        cyc(S_EXEC, 14'h0, "calc_e");
        cyc(S_WB, B_RW, "calc_wb");

        // LD with three memory wait cycles (8 cycles total)
        fetch_ok("ld_f");
        decode(16'h0A05, ST_LD, "ld_d");
        cyc(S_EXEC, 14'h0, "ld_e");
        for (int i = 0; i < 3; i++) cyc(S_MEM, B_DREQ, "ld_mw");
        dmem_ready = 1'b1;
        cyc(S_MEM, B_DREQ, "ld_mok");
        dmem_ready = 1'b0;
        cyc(S_WB, B_RW | W_MEM, "ld_wb");

        // ST zero-wait
        fetch_ok("st_f");
        decode(16'h4A05, ST_ST, "st_d");
        cyc(S_EXEC, 14'h0, "st_e");
        dmem_ready = 1'b1;
        cyc(S_MEM, B_DREQ | B_DWE, "st_m");
        dmem_ready = 1'b0;

        // Bcc not taken, then taken
        fetch_ok("bcc0_f");
        decode(16'hB800, ST_IMM, "bcc0_d");
        cyc(S_EXEC, 14'h0, "bcc0_e");
        fetch_ok("bcc1_f");
        decode(16'hB800, ST_IMM, "bcc1_d");
        branch_taken = 1'b1;
        cyc(S_EXEC, B_PCW | PC_B, "bcc1_e");
        branch_taken = 1'b0;

        // Unconditional branch
        fetch_ok("b_f");
        decode(16'hA000, ST_IMM, "b_d");
        cyc(S_EXEC, B_PCW | PC_J, "b_e");

        // LI writes the immediate
        fetch_ok("li_f");
        decode(16'h8100, ST_IMM, "li_d");
        cyc(S_EXEC, 14'h0, "li_e");
        cyc(S_WB, B_RW | W_IMM, "li_wb");

        // NOP with a stray restart: ignored outside HALT
        restart = 1'b1;
        fetch_ok("nop_f");
        decode(16'hC0E0, ST_IO, "nop_d");
        restart = 1'b0;

        // IN: five cycles waiting, accepting cycle writes back
        fetch_ok("in_f");
        decode(16'hC0C0, ST_IO, "in_d");
        for (int i = 0; i < 5; i++) cyc(S_IOWAIT, B_INR, "in_w");
        in_valid = 1'b1;
        cyc(S_IOWAIT, B_INR | B_RW | W_IN, "in_acc");
        in_valid = 1'b0;

        // OUT accepted immediately
        fetch_ok("out_f");
        decode(16'hC0D0, ST_IO, "out_d");
        out_ready = 1'b1;
        cyc(S_IOWAIT, B_OV, "out_acc");
        out_ready = 1'b0;

        // HLT; restart coincident with entering HALT is ignored
        fetch_ok("hlt_f");
        restart = 1'b1;
        decode(16'hC0F0, ST_IO, "hlt_d");
        restart = 1'b0;
        cyc(S_HALT, B_HLT, "hlt_hold");
        restart = 1'b1;
        cyc(S_HALT, B_HLT, "hlt_rs");
        cyc(S_FETCH, B_IREQ, "rs_fw");
        restart = 1'b0;
        fetch_ok("rs_f");

        // LD where ready lands on the last cycle the watchdog allows
        decode(16'h0A05, ST_LD, "wr_d");
        cyc(S_EXEC, 14'h0, "wr_e");
        for (int i = 0; i < STALL_LIMIT - 1; i++) cyc(S_MEM, B_DREQ, "wr_mw");
        dmem_ready = 1'b1;
        cyc(S_MEM, B_DREQ, "wr_mok");
        dmem_ready = 1'b0;
        cyc(S_WB, B_RW | W_MEM, "wr_wb");

        // Fetch stalls STALL_LIMIT cycles -> HALT with fault
        for (int i = 0; i < STALL_LIMIT - 1; i++) cyc(S_FETCH, B_IREQ, "wd_fw");
        restart = 1'b1;
        cyc(S_FETCH, B_IREQ, "wd_last");
        restart = 1'b0;
        cyc(S_HALT, B_HLT | B_FLT, "wd_halt");
        restart = 1'b1;
        cyc(S_HALT, B_HLT | B_FLT, "wd_rs");
        restart = 1'b0;
        fetch_ok("wd_refetch");

        // Reset asserted mid-MEM clears state and outputs before the next edge
        decode(16'h0A05, ST_LD, "ar_d");
        cyc(S_EXEC, 14'h0, "ar_e");
        cyc(S_MEM, B_DREQ, "ar_m");
        rst_n = 1'b0;
        cyc(S_IDLE, 14'h0, "ar_async");
        rst_n = 1'b1;
        cyc(S_IDLE, 14'h0, "ar_idle");
        fetch_ok("ar_f");

        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
